uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 95 +++++++++
 tb/tb_uart_tx_fifo.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through byte FIFO feeding a UART transmitter.
// Optional sticky overflow flag ovfErr is built when UART_TX_FIFO_OVF_EN is defined.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          CLK288MHZ,
  input  logic          reset,
  input  logic [7:0]    dataWr,
  input  logic          wrEn,
  output logic          full,
  output logic [7:0]    dataOut,
  output logic          fifoNE,
  input  logic          readEn,
  output logic [AW:0]   count
`ifdef UART_TX_FIFO_OVF_EN
  ,
  output logic          ovfErr
`endif
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = {{AW{1'b0}}, 1'b1};

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic        full_q, full_d;
  logic        ne_q, ne_d;
  logic        do_pop, do_write;

  // A pop frees a slot in the same edge, so a full FIFO still accepts a write.
  always_comb begin
    do_pop   = reset & readEn & ne_q;
    do_write = reset & wrEn & (~full_q | do_pop);
    wr_ptr_d = do_write ? wr_ptr_q + ONE_C : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + ONE_C : rd_ptr_q;
    count_d  = count_q;
    case ({do_write, do_pop})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
    full_d = (count_d == DEPTH_C);
    ne_d   = (count_d != '0);
  end

  always_ff @(posedge CLK288MHZ) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      ne_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      ne_q     <= ne_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge CLK288MHZ) begin
    if (do_write) begin
      mem_q[wr_ptr_q[AW-1:0]] <= dataWr;
    end
  end

  assign dataOut = mem_q[rd_ptr_q[AW-1:0]];
  assign count   = count_q;
  assign full    = full_q;
  assign fifoNE  = ne_q;

`ifdef UART_TX_FIFO_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q | (wrEn & full_q & ~(readEn & ne_q));
  end

  always_ff @(posedge CLK288MHZ) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovfErr = ovf_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo against a queue-based reference model.
// Checks ovfErr too when UART_TX_FIFO_OVF_EN is defined.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk;
  logic          reset;
  logic [7:0]    dataWr;
  logic          wrEn;
  logic          readEn;
  logic          full;
  logic [7:0]    dataOut;
  logic          fifoNE;
  logic [AW:0]   count;
`ifdef UART_TX_FIFO_OVF_EN
  logic          ovfErr;
`endif

  uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .CLK288MHZ (clk),
    .reset     (reset),
    .dataWr    (dataWr),
    .wrEn      (wrEn),
    .full      (full),
    .dataOut   (dataOut),
    .fifoNE    (fifoNE),
    .readEn    (readEn),
    .count     (count)
`ifdef UART_TX_FIFO_OVF_EN
    ,
    .ovfErr    (ovfErr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a plain byte queue plus a sticky overflow bit.
  logic [7:0] modelQ[$];
  bit         modelOvf;
  bit         lastAccepted;
  logic [7:0] lastPopped;
  int         compared;
  int         mismatched;

  // Drive one cycle of inputs and advance the model by the same edge.
  task automatic applyStimulus(input bit rstN, input bit we, input bit re, input logic [7:0] d);
    bit pop;
    bit wr;
    @(negedge clk);
    reset  = rstN;
    wrEn   = we;
    readEn = re;
    dataWr = d;
    lastAccepted = 1'b0;
    if (!rstN) begin
      modelQ.delete();
      modelOvf = 1'b0;
    end else begin
      pop = re && (modelQ.size() > 0);
      wr  = we && ((modelQ.size() < DEPTH) || pop);
      if (pop) lastPopped = modelQ.pop_front();
      if (wr) modelQ.push_back(d);
      if (we && !wr) modelOvf = 1'b1;
      lastAccepted = wr;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [AW:0] expCount;
    expCount = (AW+1)'(modelQ.size());
    checkOne({tag, ".count"}, 32'(count), 32'(expCount));
    checkOne({tag, ".full"}, 32'(full), 32'(modelQ.size() == DEPTH));
    checkOne({tag, ".fifoNE"}, 32'(fifoNE), 32'(modelQ.size() != 0));
    if (modelQ.size() != 0) checkOne({tag, ".dataOut"}, 32'(dataOut), 32'(modelQ[0]));
`ifdef UART_TX_FIFO_OVF_EN
    checkOne({tag, ".ovfErr"}, 32'(ovfErr), 32'(modelOvf));
`endif
  endtask

  initial begin
    int written;
    int guard;
    compared   = 0;
    mismatched = 0;
    modelOvf   = 1'b0;
    reset = 1'b0; wrEn = 1'b0; readEn = 1'b0; dataWr = 8'h00;

    applyStimulus(0, 0, 0, 8'h00);
    applyStimulus(0, 1, 1, 8'h99);
    checkOutput("reset");

    applyStimulus(1, 1, 0, 8'hA5);
    checkOutput("firstWrite");
    checkOne("firstWrite.A5", 32'(dataOut), 32'h A5);
    applyStimulus(1, 0, 1, 8'h00);
    checkOutput("firstPop");
    checkOne("firstPop.byte", 32'(lastPopped), 32'hA5);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, 1, 0, 8'(i));
      checkOutput("fill");
    end
    checkOne("fill.full", 32'(full), 32'h1);
    applyStimulus(1, 1, 0, 8'hFF);
    checkOutput("overflow");
    checkOne("overflow.count", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, 0, 1, 8'h00);
      checkOutput("drain");
      checkOne("drain.order", 32'(lastPopped), 32'(i));
    end

    applyStimulus(0, 0, 0, 8'h00);
    for (int i = 0; i < 16; i++) applyStimulus(1, 1, 0, 8'(i));
    applyStimulus(1, 1, 1, 8'h77);
    checkOutput("fullBoth");
    checkOne("fullBoth.pop", 32'(lastPopped), 32'h00);
    checkOne("fullBoth.full", 32'(full), 32'h1);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, 0, 1, 8'h00);
      checkOutput("fullBothDrain");
    end
    checkOne("fullBoth.last", 32'(lastPopped), 32'h77);

    applyStimulus(1, 1, 0, 8'h11);
    applyStimulus(1, 1, 1, 8'h22);
    checkOutput("oneBoth");
    checkOne("oneBoth.data", 32'(dataOut), 32'h22);
    applyStimulus(1, 0, 1, 8'h00);
    checkOutput("oneBothPop");

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 1, 8'h00);
      checkOutput("emptyRead");
    end
    applyStimulus(1, 1, 0, 8'h5A);
    checkOutput("afterEmptyRead");
    checkOne("afterEmptyRead.data", 32'(dataOut), 32'h5A);
    applyStimulus(1, 0, 1, 8'h00);
    checkOutput("afterEmptyReadPop");

    written = 0;
    guard   = 0;
    while (written < 40 && guard < 400) begin
      applyStimulus(1, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 8'(written + 8'h80));
      if (lastAccepted) written++;
      guard++;
      checkOutput("stream");
    end
    checkOne("stream.budget", 32'(written), 32'd40);
    guard = 0;
    while (modelQ.size() > 0 && guard < 40) begin
      applyStimulus(1, 0, 1, 8'h00);
      checkOutput("streamDrain");
      guard++;
    end
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, 0, 8'(8'hC0 + i));
    checkOne("preReset.count", 32'(count), 32'd5);
    applyStimulus(0, 1, 1, 8'hEE);
    checkOutput("midReset");
    applyStimulus(1, 1, 0, 8'h3C);
    checkOutput("postReset");
    checkOne("postReset.data", 32'(dataOut), 32'h3C);

    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 49) != 0, $urandom_range(0, 2) != 0,
                    $urandom_range(0, 2) == 0, 8'($urandom));
      checkOutput("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
